// File: rtl/cpu.sv
// Scalar CPU (R0-R7) with a 3x3 tensor core (T0-T17) that computes M0 x M1 one row per cycle into a result buffer.
// Latency: scalar, move and read ops take 1 cycle; TENSOR_CORE_OPERATE takes 3 cycles, done flag set on the row-2 edge.
// Backpressure: none. While a product is in flight, tensor-touching instructions are dropped as NOPs. Macro CPU_MUL_EN enables scalar MUL.
module cpu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [15:0]                  current_instruction,
    output logic signed [DATA_WIDTH-1:0] cpu_output
);

    typedef logic signed [DATA_WIDTH-1:0] word_t;

    typedef enum logic [3:0] {
        OP_ADD       = 4'b0000,
        OP_SUB       = 4'b0001,
        OP_MUL       = 4'b0010,
        OP_EQL       = 4'b0011,
        OP_GRT       = 4'b0100,
        OP_OPERATE   = 4'b0101,
        OP_LOAD      = 4'b0110,
        OP_CPU_TO_TC = 4'b0111,
        OP_TC_TO_CPU = 4'b1000,
        OP_NOP       = 4'b1001,
        OP_ADD_IMM   = 4'b1010,
        OP_MOVE_CPU  = 4'b1011,
        OP_MOVE_TC   = 4'b1100,
        OP_RESET     = 4'b1101,
        OP_READ_CPU  = 4'b1110,
        OP_READ_TC   = 4'b1111
    } opcode_t;

    localparam logic [4:0] NUM_T = 5'd18;

    word_t regs   [8];
    word_t tens   [18];
    word_t result [9];

    logic       is_tensor_core_done_with_calculation;
    logic       busy;
    logic [1:0] row_cnt;

    // Instruction fields
    opcode_t    opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [4:0] ti;
    logic [4:0] td;
    logic       load_sel;
    word_t      imm_ext;
    logic       unused_ok;

    assign opcode    = opcode_t'(current_instruction[15:12]);
    assign rd        = current_instruction[10:8];
    assign rs1       = current_instruction[6:4];
    assign rs2       = current_instruction[2:0];
    assign ti        = current_instruction[4:0];
    assign td        = current_instruction[9:5];
    assign load_sel  = current_instruction[8];
    assign imm_ext   = word_t'(signed'(current_instruction[7:0]));
    assign unused_ok = &{1'b0, current_instruction[11]};

    // Operand values; tensor indices past T17 read as zero
    word_t rs1_val;
    word_t rs2_val;
    word_t rd_val;
    word_t t_val;
    word_t eq_val;
    word_t gt_val;
    logic  td_ok;

    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign rd_val  = regs[rd];
    assign t_val   = (ti < NUM_T) ? tens[ti] : '0;
    assign td_ok   = (td < NUM_T);
    assign eq_val  = {{(DATA_WIDTH-1){1'b0}}, (rs1_val == rs2_val)};
    assign gt_val  = {{(DATA_WIDTH-1){1'b0}}, (rs1_val > rs2_val)};

`ifdef CPU_MUL_EN
    word_t mul_val;
    assign mul_val = rs1_val * rs2_val;
`endif

    // One row of M0 x M1 for the row the counter points at; products and sum wrap at DATA_WIDTH
    logic [3:0] row_base;
    word_t      row_val [3];

    always_comb begin
        case (row_cnt)
            2'd0:    row_base = 4'd0;
            2'd1:    row_base = 4'd3;
            default: row_base = 4'd6;
        endcase
        for (int c = 0; c < 3; c++) begin
            row_val[c] = '0;
            for (int k = 0; k < 3; k++) begin
                row_val[c] = row_val[c] + word_t'(tens[{1'b0, row_base} + 5'(k)] * tens[9 + 3*k + c]);
            end
        end
    end

    // All architectural state: reset (pin or opcode) wins, otherwise the product advances and the instruction executes
    always_ff @(posedge clock_in) begin
        if (reset_in || opcode == OP_RESET) begin
            for (int i = 0; i < 8; i++)  regs[i]   <= '0;
            for (int i = 0; i < 18; i++) tens[i]   <= '0;
            for (int i = 0; i < 9; i++)  result[i] <= '0;
            cpu_output                           <= '0;
            is_tensor_core_done_with_calculation <= 1'b0;
            busy                                 <= 1'b0;
            row_cnt                              <= 2'd0;
        end else begin
            if (busy) begin
                for (int c = 0; c < 3; c++) result[row_base + 4'(c)] <= row_val[c];
                if (row_cnt == 2'd2) begin
                    busy                                 <= 1'b0;
                    row_cnt                              <= 2'd0;
                    is_tensor_core_done_with_calculation <= 1'b1;
                end else begin
                    row_cnt <= row_cnt + 2'd1;
                end
            end

            case (opcode)
                OP_ADD:      regs[rd] <= rs1_val + rs2_val;
                OP_SUB:      regs[rd] <= rs1_val - rs2_val;
`ifdef CPU_MUL_EN
                OP_MUL:      regs[rd] <= mul_val;
`endif
                OP_EQL:      regs[rd] <= eq_val;
                OP_GRT:      regs[rd] <= gt_val;
                OP_ADD_IMM:  regs[rd] <= rd_val + imm_ext;
                OP_MOVE_CPU: regs[rd] <= rs2_val;
                OP_READ_CPU: cpu_output <= rs2_val;
                OP_OPERATE: begin
                    if (!busy) begin
                        busy                                 <= 1'b1;
                        row_cnt                              <= 2'd0;
                        is_tensor_core_done_with_calculation <= 1'b0;
                    end
                end
                OP_LOAD: begin
                    if (!busy) begin
                        for (int i = 0; i < 9; i++) begin
                            if (load_sel) tens[9 + i] <= result[i];
                            else          tens[i]     <= result[i];
                        end
                    end
                end
                OP_CPU_TO_TC: if (!busy && td_ok) tens[td] <= rs2_val;
                OP_TC_TO_CPU: if (!busy) regs[rd] <= t_val;
                OP_MOVE_TC:   if (!busy && td_ok) tens[td] <= t_val;
                OP_READ_TC:   if (!busy) cpu_output <= t_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic               clock_in;
    logic               reset_in;
    logic [15:0]        current_instruction;
    logic signed [7:0]  cpu_output;

    int errors = 0;
    int checks = 0;

    cpu #(.DATA_WIDTH(8)) dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .current_instruction (current_instruction),
        .cpu_output          (cpu_output)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Reference model: architectural state plus a countdown for the in-flight product
    byte mr    [8];
    byte mt    [18];
    byte mres  [9];
    byte mpend [9];
    byte mout;
    bit  mdone;
    int  mbusy;

    function automatic byte tread(int idx);
        return (idx < 18) ? mt[idx] : 8'sd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++)  mr[i]   = 0;
        for (int i = 0; i < 18; i++) mt[i]   = 0;
        for (int i = 0; i < 9; i++)  mres[i] = 0;
        mout  = 0;
        mdone = 1'b0;
        mbusy = 0;
    endtask

    task automatic model_step(input logic [15:0] ins, input bit rst);
        logic [3:0] op;
        int rd, rs1, rs2, ti, td, sum;
        byte imm;
        bit blk;
        op  = ins[15:12];
        rd  = int'(ins[10:8]);
        rs1 = int'(ins[6:4]);
        rs2 = int'(ins[2:0]);
        ti  = int'(ins[4:0]);
        td  = int'(ins[9:5]);
        imm = byte'(ins[7:0]);
        if (rst || op == 4'hD) begin
            model_clear();
            return;
        end
        blk = (mbusy != 0);
        if (blk) begin
            mbusy--;
            if (mbusy == 0) begin
                mdone = 1'b1;
                mres  = mpend;
            end
        end
        case (op)
            4'h0: mr[rd] = byte'(int'(mr[rs1]) + int'(mr[rs2]));
            4'h1: mr[rd] = byte'(int'(mr[rs1]) - int'(mr[rs2]));
`ifdef CPU_MUL_EN
            4'h2: mr[rd] = byte'(int'(mr[rs1]) * int'(mr[rs2]));
`endif
            4'h3: mr[rd] = (mr[rs1] == mr[rs2]) ? 8'sd1 : 8'sd0;
            4'h4: mr[rd] = (mr[rs1] > mr[rs2]) ? 8'sd1 : 8'sd0;
            4'h5: if (!blk) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        sum = 0;
                        for (int k = 0; k < 3; k++) sum += int'(mt[r*3+k]) * int'(mt[9+k*3+c]);
                        mpend[r*3+c] = byte'(sum);
                    end
                mbusy = 3;
                mdone = 1'b0;
            end
            4'h6: if (!blk) for (int i = 0; i < 9; i++) mt[(ins[8] ? 9 : 0) + i] = mres[i];
            4'h7: if (!blk && td < 18) mt[td] = mr[rs2];
            4'h8: if (!blk) mr[rd] = tread(ti);
            4'hA: mr[rd] = byte'(int'(mr[rd]) + int'(imm));
            4'hB: mr[rd] = mr[rs2];
            4'hC: if (!blk && td < 18) mt[td] = tread(ti);
            4'hE: mout = mr[rs2];
            4'hF: if (!blk) mout = tread(ti);
            default: ;
        endcase
    endtask

    // Apply one instruction for one clock, advance the model, compare output and done flag
    task automatic step(input string tag, input logic [15:0] ins, input bit rst);
        current_instruction = ins;
        reset_in            = rst;
        @(posedge clock_in);
        model_step(ins, rst);
        #1;
        checks++;
        assert (cpu_output === mout) else begin
            errors++;
            $error("FAIL %s cpu_output observed=%0d expected=%0d", tag, cpu_output, mout);
        end
        checks++;
        assert (dut.is_tensor_core_done_with_calculation === mdone) else begin
            errors++;
            $error("FAIL %s done observed=%0b expected=%0b", tag, dut.is_tensor_core_done_with_calculation, mdone);
        end
    endtask

    task automatic chk_out(input string tag, input byte exp);
        checks++;
        assert (cpu_output === exp) else begin
            errors++;
            $error("FAIL %s cpu_output observed=%0d expected=%0d", tag, cpu_output, exp);
        end
    endtask

    task automatic chk_done(input string tag, input bit exp);
        checks++;
        assert (dut.is_tensor_core_done_with_calculation === exp) else begin
            errors++;
            $error("FAIL %s done observed=%0b expected=%0b", tag, dut.is_tensor_core_done_with_calculation, exp);
        end
    endtask

    function automatic logic [15:0] i_rrr(logic [3:0] op, int rd, int rs1, int rs2);
        return {op, 1'b0, 3'(rd), 1'b0, 3'(rs1), 1'b0, 3'(rs2)};
    endfunction

    function automatic logic [15:0] i_imm(int rd, byte imm);
        return {4'b1010, 1'b0, 3'(rd), imm};
    endfunction

    function automatic logic [15:0] i_tt(logic [3:0] op, int td, int ti);
        return {op, 2'b00, 5'(td), 5'(ti)};
    endfunction

    function automatic logic [15:0] i_c2t(int td, int rs2);
        return {4'b0111, 2'b00, 5'(td), 2'b00, 3'(rs2)};
    endfunction

    function automatic logic [15:0] i_load(int sel);
        return {4'b0110, 3'b000, 1'(sel), 8'h00};
    endfunction

    localparam logic [15:0] NOP     = 16'h9000;
    localparam logic [15:0] OPERATE = 16'h5000;
    localparam logic [15:0] RST_OP  = 16'hD000;

    initial begin
        byte exp_mul;
        logic [3:0] op;
        logic [15:0] ins;
        int r;
        bit rst;

        model_clear();
        reset_in            = 1'b1;
        current_instruction = NOP;

        // Reset state
        step("reset0", NOP, 1'b1);
        step("reset1", NOP, 1'b1);
        chk_out("reset_out", 8'sd0);
        chk_done("reset_done", 1'b0);

        // Immediate add and register add
        step("addi_r1", i_imm(1, 8'sd5), 1'b0);
        step("addi_r2", i_imm(2, -8'sd3), 1'b0);
        step("add_r3", i_rrr(4'h0, 3, 1, 2), 1'b0);
        step("read_r3", i_rrr(4'hE, 0, 0, 3), 1'b0);
        chk_out("add_imm_sum", 8'sd2);

        // Overflow wrap, signed compare, equality, multiply
        step("rst_a", NOP, 1'b1);
        step("addi_127", i_imm(1, 8'sd127), 1'b0);
        step("addi_1", i_imm(2, 8'sd1), 1'b0);
        step("add_r4", i_rrr(4'h0, 4, 1, 2), 1'b0);
        step("read_r4", i_rrr(4'hE, 0, 0, 4), 1'b0);
        chk_out("add_wrap", -8'sd128);
        step("grt_r5", i_rrr(4'h4, 5, 1, 2), 1'b0);
        step("read_r5", i_rrr(4'hE, 0, 0, 5), 1'b0);
        chk_out("grt", 8'sd1);
        step("grt_r5b", i_rrr(4'h4, 5, 4, 2), 1'b0);
        step("read_r5b", i_rrr(4'hE, 0, 0, 5), 1'b0);
        chk_out("grt_neg", 8'sd0);
        step("eql_r6", i_rrr(4'h3, 6, 2, 2), 1'b0);
        step("read_r6", i_rrr(4'hE, 0, 0, 6), 1'b0);
        chk_out("eql", 8'sd1);
        step("sub_r3", i_rrr(4'h1, 3, 4, 2), 1'b0);
        step("read_r3s", i_rrr(4'hE, 0, 0, 3), 1'b0);
        chk_out("sub_wrap", 8'sd127);
        step("mul_r7", i_rrr(4'h2, 7, 1, 2), 1'b0);
        step("read_r7", i_rrr(4'hE, 0, 0, 7), 1'b0);
`ifdef CPU_MUL_EN
        exp_mul = 8'sd127;
`else
        exp_mul = 8'sd0;
`endif
        chk_out("mul", exp_mul);

        // M0 = 1..9, M1 = identity, then product and load into matrix 1
        step("rst_b", RST_OP, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step("m0_inc", i_imm(0, 8'sd1), 1'b0);
            step("m0_wr", i_c2t(i, 0), 1'b0);
        end
        step("one", i_imm(1, 8'sd1), 1'b0);
        step("id0", i_c2t(9, 1), 1'b0);
        step("id1", i_c2t(13, 1), 1'b0);
        step("id2", i_c2t(17, 1), 1'b0);
        step("read_r0", i_rrr(4'hE, 0, 0, 0), 1'b0);
        chk_out("pre_operate", 8'sd9);
        step("operate", OPERATE, 1'b0);
        chk_done("operate_clr", 1'b0);
        step("busy_read_tc", i_tt(4'hF, 0, 0), 1'b0);
        chk_out("busy_read_ignored", 8'sd9);
        step("busy_add", i_rrr(4'h0, 2, 0, 1), 1'b0);
        chk_done("busy_not_done", 1'b0);
        step("busy_nop", NOP, 1'b0);
        chk_done("done_set", 1'b1);
        step("load1", i_load(1), 1'b0);
        for (int i = 0; i < 9; i++) begin
            step("read_p", i_tt(4'hF, 0, 9 + i), 1'b0);
            chk_out("product", byte'(i + 1));
        end
        step("read_r2", i_rrr(4'hE, 0, 0, 2), 1'b0);
        chk_out("busy_add_ran", 8'sd10);

        // Out-of-range tensor index
        step("wr_t20", i_c2t(20, 0), 1'b0);
        step("read_t20", i_tt(4'hF, 0, 20), 1'b0);
        chk_out("t20_zero", 8'sd0);
        step("read_t0", i_tt(4'hF, 0, 0), 1'b0);
        chk_out("t0", 8'sd1);

        // reset_in in the second OPERATE cycle
        step("read_r2b", i_rrr(4'hE, 0, 0, 2), 1'b0);
        step("operate2", OPERATE, 1'b0);
        step("op2_nop", NOP, 1'b0);
        step("op2_rst", i_imm(1, 8'sd5), 1'b1);
        chk_out("rst_mid_out", 8'sd0);
        chk_done("rst_mid_done", 1'b0);
        for (int i = 0; i < 8; i++) step("rst_rd_r", i_rrr(4'hE, 0, 0, i), 1'b0);
        for (int i = 0; i < 18; i++) step("rst_rd_t", i_tt(4'hF, 0, i), 1'b0);
        chk_out("rst_cleared", 8'sd0);

        // RESET opcode in the second OPERATE cycle
        step("addi_r3", i_imm(3, 8'sd7), 1'b0);
        step("wr_t4", i_c2t(4, 3), 1'b0);
        step("read_r3c", i_rrr(4'hE, 0, 0, 3), 1'b0);
        chk_out("pre_rstop", 8'sd7);
        step("operate3", OPERATE, 1'b0);
        step("op3_nop", NOP, 1'b0);
        step("op3_rstop", RST_OP, 1'b0);
        chk_out("rstop_out", 8'sd0);
        chk_done("rstop_done", 1'b0);
        step("rstop_rd_r3", i_rrr(4'hE, 0, 0, 3), 1'b0);
        step("rstop_rd_t4", i_tt(4'hF, 0, 4), 1'b0);
        chk_out("rstop_cleared", 8'sd0);

        // Randomized instruction stream against the model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 19);
            if (r >= 16) op = (r < 18) ? 4'hE : 4'hF;
            else         op = 4'(r);
            if (op == 4'hD && $urandom_range(0, 9) != 0) op = 4'h9;
            ins = 16'($urandom);
            ins[15:12] = op;
            rst = ($urandom_range(0, 199) == 0);
            step("rand", ins, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every CPU register, every tensor element and cpu_output; all data is two's-complement signed.
REQ-002 Port clock_in, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset_in, input, 1: reset is synchronous and active-high.
REQ-004 Port current_instruction, input, 16: instruction sampled on every rising clock edge; opcode = [15:12].
REQ-005 Port cpu_output, output, DATA_WIDTH signed: registered read-back value.

Function
REQ-006 The block SHALL contain 8 CPU registers R0-R7 and 18 tensor elements T0-T17; T index = m*9 + row*3 + col, matrix m in {0,1}, row and col in 0..2.
REQ-007 Field map: rd = [10:8], rs1 = [6:4], rs2 = [2:0], tensor index ti = [4:0], tensor destination td = [9:5], imm = [7:0] signed; unused bits are ignored.
REQ-008 Single-cycle ops (result visible the cycle after the edge):
- ADD 0000: rd = rs1 + rs2.
- SUB 0001: rd = rs1 - rs2.
- MUL 0010: rd = low 8 bits of rs1*rs2.
- EQL 0011: rd = (rs1 == rs2) ? 1 : 0.
- GRT 0100: rd = (rs1 > rs2, signed) ? 1 : 0.
- ADD_IMM 1010: rd = rd + imm.
- All results wrap modulo 2^8.
REQ-009 Move ops:
- MOVE_CPU 1011: rd = R[rs2].
- CPU_TO_TENSOR_CORE 0111: T[td] = R[rs2].
- TENSOR_CORE_TO_CPU 1000: rd = T[ti].
- MOVE_TENSOR_CORE 1100: T[td] = T[ti].
REQ-010 READ_CPU 1110 SHALL load cpu_output with R[rs2]; READ_TENSOR_CORE 1111 SHALL load cpu_output with T[ti]; all other opcodes hold cpu_output.
REQ-011 Tensor indices 18-31: reads return 0; writes are discarded.
REQ-012 TENSOR_CORE_OPERATE 0101 SHALL compute P = M0 x M1 (3x3 matrix product) into an internal 9-element result buffer.
- One row is computed per cycle, rows 0, 1, 2.
- Each element is the sum of three 8-bit products, truncated to 8 bits (wrap).
REQ-013 Internal flag is_tensor_core_done_with_calculation:
- Cleared on the OPERATE edge.
- Set on the edge that writes row 2 (3 cycles after issue).
- Held high until the next OPERATE or reset.
REQ-014 TENSOR_CORE_LOAD 0110 SHALL copy the result buffer into matrix [8] (0 = T0-T8, 1 = T9-T17) in one cycle.
REQ-015 Busy window: while OPERATE is in progress, any instruction that reads or writes the tensor elements or the result buffer SHALL be ignored as a NOP; CPU-only instructions execute normally.
REQ-016 A second OPERATE issued while busy SHALL be ignored.
REQ-017 NOP 1001 SHALL change no state.
REQ-018 RESET 1101 SHALL have exactly the effect of reset_in for one cycle.
REQ-019 If reset_in and any instruction coincide, reset SHALL win.

Reset
REQ-020 On reset_in = 1 at a rising edge the following SHALL all clear to 0, aborting any in-flight OPERATE:
- R0-R7, T0-T17 and the result buffer.
- cpu_output.
- is_tensor_core_done_with_calculation and the row counter.
REQ-021 Reset SHALL take effect in one cycle; the instruction presented on the first edge after reset_in falls SHALL execute.

Configuration
REQ-022 Macro CPU_MUL_EN:
- Defined: the MUL opcode 0010 is implemented per REQ-008.
- Undefined: MUL is a NOP and no scalar multiplier is synthesized.
- The tensor core multipliers are unaffected either way.

Verification
REQ-023 ADD_IMM R1,+5; ADD_IMM R2,-3; ADD R3,R1,R2; READ_CPU R3 -> cpu_output = 2.
REQ-024 R1 = 127, R2 = 1; ADD R4,R1,R2 -> R4 = -128; GRT R5,R1,R2 -> R5 = 1; EQL R6,R2,R2 -> R6 = 1; with CPU_MUL_EN, MUL R7,R1,R2 -> R7 = 127.
REQ-025 Load M0 = [1 2 3; 4 5 6; 7 8 9] and M1 = identity via CPU_TO_TENSOR_CORE; OPERATE; 3 NOPs -> done = 1; TENSOR_CORE_LOAD [8]=1 -> T9-T17 = 1..9.
REQ-026 Issue READ_TENSOR_CORE T0 one cycle after OPERATE -> ignored, cpu_output unchanged; ADD issued in the same window -> executes.
REQ-027 Write T20 = 9, then READ_TENSOR_CORE T20 -> cpu_output = 0.
REQ-028 Assert reset_in during the second OPERATE cycle -> all registers, T elements, cpu_output and done = 0 on the next cycle; RESET opcode -> identical result.
